// File: rtl/spectrum_bar_shaper.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_bar_shaper
// Description : Turns each 16-bin FFT magnitude frame into display bar heights
//               with instant attack / linear release, plus peak-hold markers.
//               Bins are snapshotted on `done`, processed one per cycle, and
//               the finished frame is published atomically.
// Ports       : clk         - system clock (rising edge)
//               reset       - asynchronous, active-low reset
//               done        - one-cycle frame strobe; bins_in valid with it
//               bins_in     - 16 x 24-bit magnitudes, bin k at [24k+23:24k]
//               bars_out    - 16 x 6-bit bar heights, bar k at [6k+5:6k]
//               peaks_out   - 16 x 6-bit peak heights, same packing
//               frame_valid - one-cycle pulse when outputs were refreshed
//               busy        - high while a frame is in progress
//               overrun     - sticky, set when done arrives while busy
// Revision    : 1.0 - initial release
// ============================================================================
module spectrum_bar_shaper #(
  parameter int SHIFT       = 10,
  parameter int HOLD_FRAMES = 8,
  parameter int DECAY       = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         done,
  input  logic [383:0] bins_in,
  output logic [95:0]  bars_out,
  output logic [95:0]  peaks_out,
  output logic         frame_valid,
  output logic         busy,
  output logic         overrun
);

  localparam logic [5:0] c_decay = 6'(DECAY);
  localparam logic [7:0] c_hold  = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [383:0]  snap_q, snap_d;
  logic [5:0]    bar_q [16];
  logic [5:0]    bar_d [16];
  logic [5:0]    pk_q  [16];
  logic [5:0]    pk_d  [16];
  logic [7:0]    hold_q[16];
  logic [7:0]    hold_d[16];
  logic [95:0]   bars_out_q, bars_out_d;
  logic [95:0]   peaks_out_q, peaks_out_d;
  logic          frame_valid_q, frame_valid_d;
  logic          overrun_q, overrun_d;

  // Per-bin datapath for the bin currently addressed by idx_q
  logic [23:0]   bin_arr[16];
  logic [23:0]   bin_w, shifted;
  logic [5:0]    lvl, bar_cur, pk_cur, bar_dec, pk_dec, bar_new, pk_tmp, pk_new;
  logic [7:0]    hold_cur, hold_new;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      bin_arr[k] = snap_q[24*k +: 24];
    end
    bin_w   = bin_arr[idx_q];
    shifted = bin_w >> SHIFT;
    // Saturate on the full-width value so large magnitudes never wrap.
    lvl     = (shifted > 24'd63) ? 6'd63 : shifted[5:0];

    bar_cur  = bar_q[idx_q];
    pk_cur   = pk_q[idx_q];
    hold_cur = hold_q[idx_q];

    bar_dec = (bar_cur > c_decay) ? (bar_cur - c_decay) : 6'd0;
    if (lvl >= bar_cur) begin
      bar_new = lvl;
    end else begin
      bar_new = (lvl > bar_dec) ? lvl : bar_dec;
    end

    pk_dec   = (pk_cur > c_decay) ? (pk_cur - c_decay) : 6'd0;
    hold_new = hold_cur;
    if (lvl >= pk_cur) begin
      pk_tmp   = lvl;
      hold_new = c_hold;
    end else if (hold_cur != 8'd0) begin
      pk_tmp   = pk_cur;
      hold_new = hold_cur - 8'd1;
    end else begin
      pk_tmp = (lvl > pk_dec) ? lvl : pk_dec;
    end
    // Keep the marker at or above the bar it belongs to.
    pk_new = (pk_tmp >= bar_new) ? pk_tmp : bar_new;
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    bar_d         = bar_q;
    pk_d          = pk_q;
    hold_d        = hold_q;
    bars_out_d    = bars_out_q;
    peaks_out_d   = peaks_out_q;
    frame_valid_d = 1'b0;
    overrun_d     = overrun_q;

    case (state_q)
      IDLE: begin
        if (done) begin
          state_d = SCAN;
          snap_d  = bins_in;
          idx_d   = 4'd0;
        end
      end
      SCAN: begin
        if (done) overrun_d = 1'b1;
        bar_d[idx_q]  = bar_new;
        pk_d[idx_q]   = pk_new;
        hold_d[idx_q] = hold_new;
        idx_d         = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = PUBLISH;
      end
      PUBLISH: begin
        if (done) overrun_d = 1'b1;
        for (int k = 0; k < 16; k++) begin
          bars_out_d[6*k +: 6]  = bar_q[k];
          peaks_out_d[6*k +: 6] = pk_q[k];
        end
        frame_valid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= 4'd0;
      snap_q        <= '0;
      bars_out_q    <= '0;
      peaks_out_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        bar_q[k]  <= 6'd0;
        pk_q[k]   <= 6'd0;
        hold_q[k] <= 8'd0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      bars_out_q    <= bars_out_d;
      peaks_out_q   <= peaks_out_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      for (int k = 0; k < 16; k++) begin
        bar_q[k]  <= bar_d[k];
        pk_q[k]   <= pk_d[k];
        hold_q[k] <= hold_d[k];
      end
    end
  end

  assign bars_out    = bars_out_q;
  assign peaks_out   = peaks_out_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire
